// File: rtl/cmp_engine_if.sv
// Operand/function bus and result bus of the compare engine.
// The master drives operands and controls; the slave (cmp_engine) returns results.
interface cmp_engine_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALU_FUN;
  logic             SIGNED_MODE;
  logic             CMP_EN;
  logic             CNT_CLR;
  logic [1:0]       CMP_OUT;
  logic             CMP_Flag;
  logic [CNT_W-1:0] TRUE_CNT;
  logic [WIDTH-1:0] RUN_MAX;
  logic [WIDTH-1:0] RUN_MIN;

  modport master (
    output A, B, ALU_FUN, SIGNED_MODE, CMP_EN, CNT_CLR,
    input  CMP_OUT, CMP_Flag, TRUE_CNT, RUN_MAX, RUN_MIN
  );

  modport slave (
    input  A, B, ALU_FUN, SIGNED_MODE, CMP_EN, CNT_CLR,
    output CMP_OUT, CMP_Flag, TRUE_CNT, RUN_MAX, RUN_MIN
  );
endinterface

// File: rtl/cmp_engine.sv
// Two-stage pipelined signed/unsigned comparator with saturating true-result counter.
// Define CMP_TRACK_EN to build the running max/min tracker of operand A.
module cmp_engine #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input logic         CLK,
  input logic         RST,
  cmp_engine_if.slave bus
);
  localparam int STAGES = 1;

  localparam logic [2:0] FUN_NOP  = 3'd0;
  localparam logic [2:0] FUN_EQ   = 3'd1;
  localparam logic [2:0] FUN_GT   = 3'd2;
  localparam logic [2:0] FUN_LT   = 3'd3;
  localparam logic [2:0] FUN_CMP3 = 3'd4;
  localparam logic [2:0] FUN_NE   = 3'd5;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       fun;
    logic             sm;
  } req_t;

  // vld_pipe[0] is the S1 valid, vld_pipe[STAGES] is CMP_Flag
  logic [STAGES:0]  vld_pipe;
  req_t             s1;
  logic [1:0]       cmp_out;
  logic [CNT_W-1:0] true_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_pipe <= '0;
      s1       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], bus.CMP_EN};
      if (bus.CMP_EN)
        s1 <= '{a: bus.A, b: bus.B, fun: bus.ALU_FUN, sm: bus.SIGNED_MODE};
    end
  end

  logic       eq, gt, lt;
  logic [1:0] res;
  logic       wr_res;

  always_comb begin
    eq = (s1.a == s1.b);
    if (s1.sm) gt = $signed(s1.a) > $signed(s1.b);
    else       gt = s1.a > s1.b;
    lt = !eq && !gt;
    res = 2'd0;
    case (s1.fun)
      FUN_EQ:   res = eq ? 2'd1 : 2'd0;
      FUN_GT:   res = gt ? 2'd2 : 2'd0;
      FUN_LT:   res = lt ? 2'd3 : 2'd0;
      FUN_CMP3: res = eq ? 2'd1 : (gt ? 2'd2 : 2'd3);
      FUN_NE:   res = eq ? 2'd0 : 2'd1;
      default:  res = 2'd0;
    endcase
  end

  // NOP still pulses the flag but leaves CMP_OUT and the counter alone
  assign wr_res = vld_pipe[0] && (s1.fun != FUN_NOP);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cmp_out  <= '0;
      true_cnt <= '0;
    end else begin
      if (wr_res) cmp_out <= res;
      if (bus.CNT_CLR)
        true_cnt <= '0;
      else if (wr_res && res != 2'd0 && true_cnt != CNT_MAX)
        true_cnt <= true_cnt + CNT_W'(1);
    end
  end

  assign bus.CMP_OUT  = cmp_out;
  assign bus.CMP_Flag = vld_pipe[STAGES];
  assign bus.TRUE_CNT = true_cnt;

`ifdef CMP_TRACK_EN
  logic [WIDTH-1:0] run_max, run_min;
  logic             trk_empty;
  logic             a_gt_max, a_lt_min;

  // Ordering follows the mode of the op being tracked, not the mode of earlier ops
  always_comb begin
    if (s1.sm) begin
      a_gt_max = $signed(s1.a) > $signed(run_max);
      a_lt_min = $signed(s1.a) < $signed(run_min);
    end else begin
      a_gt_max = s1.a > run_max;
      a_lt_min = s1.a < run_min;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      run_max   <= '0;
      run_min   <= '0;
      trk_empty <= 1'b1;
    end else if (bus.CNT_CLR) begin
      run_max   <= '0;
      run_min   <= '0;
      trk_empty <= 1'b1;
    end else if (vld_pipe[0]) begin
      trk_empty <= 1'b0;
      if (trk_empty || a_gt_max) run_max <= s1.a;
      if (trk_empty || a_lt_min) run_min <= s1.a;
    end
  end

  assign bus.RUN_MAX = run_max;
  assign bus.RUN_MIN = run_min;
`else
  assign bus.RUN_MAX = '0;
  assign bus.RUN_MIN = '0;
`endif
endmodule

// File: tb/tb_cmp_engine.sv
// Directed + randomized bench for cmp_engine against an operation-level reference model.
// A second instance with CNT_W=2 shares the same stimulus to exercise counter saturation.
module tb_cmp_engine;
  localparam int W = 16;

`ifdef CMP_TRACK_EN
  localparam bit TRK = 1'b1;
`else
  localparam bit TRK = 1'b0;
`endif

  logic CLK;
  logic RST;

  cmp_engine_if #(.WIDTH(W), .CNT_W(8)) bus ();
  cmp_engine_if #(.WIDTH(W), .CNT_W(2)) bus2 ();

  assign bus2.A           = bus.A;
  assign bus2.B           = bus.B;
  assign bus2.ALU_FUN     = bus.ALU_FUN;
  assign bus2.SIGNED_MODE = bus.SIGNED_MODE;
  assign bus2.CMP_EN      = bus.CMP_EN;
  assign bus2.CNT_CLR     = bus.CNT_CLR;

  cmp_engine #(.WIDTH(W), .CNT_W(8)) dut  (.CLK(CLK), .RST(RST), .bus(bus));
  cmp_engine #(.WIDTH(W), .CNT_W(2)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int stepno = 0;

  // Reference model: one op in flight, plus the architectural outputs
  bit          pv;
  logic [2:0]  pfun;
  bit          psm;
  logic [W-1:0] pa, pb;
  logic [1:0]  e_out;
  bit          e_flag;
  int          e_cnt8, e_cnt2;
  logic [W-1:0] e_max, e_min;
  bit          e_empty;

  function automatic longint val(input logic [W-1:0] x, input bit sm);
    if (sm) return longint'($signed(x));
    return longint'({1'b0, x});
  endfunction

  function automatic logic [1:0] ref_res(input logic [2:0] fun, input bit sm,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    longint va, vb;
    va = val(a, sm);
    vb = val(b, sm);
    case (fun)
      3'd1: return (va == vb) ? 2'd1 : 2'd0;
      3'd2: return (va > vb)  ? 2'd2 : 2'd0;
      3'd3: return (va < vb)  ? 2'd3 : 2'd0;
      3'd4: return (va == vb) ? 2'd1 : ((va > vb) ? 2'd2 : 2'd3);
      3'd5: return (va != vb) ? 2'd1 : 2'd0;
      default: return 2'd0;
    endcase
  endfunction

  task automatic model_reset();
    pv = 0; e_out = 0; e_flag = 0; e_cnt8 = 0; e_cnt2 = 0;
    e_max = 0; e_min = 0; e_empty = 1;
  endtask

  task automatic model_edge(input bit en, input logic [2:0] fun, input bit sm,
                            input logic [W-1:0] a, input logic [W-1:0] b, input bit clr);
    logic [1:0] r;
    bit counted;
    counted = 0;
    e_flag = pv;
    if (pv && pfun != 3'd0) begin
      r = ref_res(pfun, psm, pa, pb);
      e_out = r;
      counted = (r != 2'd0);
    end
    if (clr) begin
      e_cnt8 = 0; e_cnt2 = 0;
    end else if (counted) begin
      if (e_cnt8 < 255) e_cnt8++;
      if (e_cnt2 < 3) e_cnt2++;
    end
    if (TRK) begin
      if (clr) begin
        e_max = 0; e_min = 0; e_empty = 1;
      end else if (pv) begin
        if (e_empty) begin
          e_max = pa; e_min = pa;
        end else begin
          if (val(pa, psm) > val(e_max, psm)) e_max = pa;
          if (val(pa, psm) < val(e_min, psm)) e_min = pa;
        end
        e_empty = 0;
      end
    end
    pv = en; pfun = fun; psm = sm; pa = a; pb = b;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, stepno, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cmp_out",  32'(bus.CMP_OUT),   32'(e_out));
    chk("flag",     32'(bus.CMP_Flag),  32'(e_flag));
    chk("cnt8",     32'(bus.TRUE_CNT),  32'(e_cnt8));
    chk("cnt2",     32'(bus2.TRUE_CNT), 32'(e_cnt2));
    chk("flag2",    32'(bus2.CMP_Flag), 32'(e_flag));
    chk("run_max",  32'(bus.RUN_MAX),   32'(e_max));
    chk("run_min",  32'(bus.RUN_MIN),   32'(e_min));
  endtask

  task automatic step(input bit en, input logic [2:0] fun, input bit sm,
                      input logic [W-1:0] a, input logic [W-1:0] b, input bit clr);
    bus.CMP_EN = en; bus.ALU_FUN = fun; bus.SIGNED_MODE = sm;
    bus.A = a; bus.B = b; bus.CNT_CLR = clr;
    @(posedge CLK); #1;
    stepno++;
    model_edge(en, fun, sm, a, b, clr);
    check_all();
  endtask

  task automatic idle(input bit clr);
    step(1'b0, 3'd0, 1'b0, '0, '0, clr);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W-1:0] corners [4];
    corners[0] = 16'h0000; corners[1] = 16'h7FFF;
    corners[2] = 16'h8000; corners[3] = 16'hFFFF;

    RST = 1'b0;
    bus.CMP_EN = 0; bus.ALU_FUN = 0; bus.SIGNED_MODE = 0;
    bus.A = 0; bus.B = 0; bus.CNT_CLR = 0;
    model_reset();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check_all();
    RST = 1'b1;

    // signed -1 vs 1: GT false, LT true
    step(1, 3'd2, 1, 16'hFFFF, 16'h0001, 0);
    step(1, 3'd3, 1, 16'hFFFF, 16'h0001, 0);
    chk("t1s_gt_out", 32'(bus.CMP_OUT), 32'd0);
    chk("t1s_gt_flag", 32'(bus.CMP_Flag), 32'd1);
    idle(0);
    chk("t1s_lt_out", 32'(bus.CMP_OUT), 32'd3);
    idle(0);
    chk("t1s_idle_flag", 32'(bus.CMP_Flag), 32'd0);
    // same operands unsigned: 0xFFFF > 1
    step(1, 3'd2, 0, 16'hFFFF, 16'h0001, 0);
    step(1, 3'd3, 0, 16'hFFFF, 16'h0001, 0);
    chk("t1u_gt_out", 32'(bus.CMP_OUT), 32'd2);
    idle(0);
    chk("t1u_lt_out", 32'(bus.CMP_OUT), 32'd0);

    // CMP3 eq / lt / gt
    idle(1);
    step(1, 3'd4, 0, 16'h1234, 16'h1234, 0);
    step(1, 3'd4, 0, 16'd5, 16'd9, 0);
    chk("t2_eq", 32'(bus.CMP_OUT), 32'd1);
    step(1, 3'd4, 0, 16'd9, 16'd5, 0);
    chk("t2_lt", 32'(bus.CMP_OUT), 32'd3);
    idle(0);
    chk("t2_gt", 32'(bus.CMP_OUT), 32'd2);
    chk("t2_cnt", 32'(bus.TRUE_CNT), 32'd3);

    // 2-bit counter saturation, then clear beating a counting result
    idle(1);
    for (int i = 0; i < 5; i++) step(1, 3'd1, 0, 16'h00AA, 16'h00AA, 0);
    idle(0);
    chk("t3_sat2", 32'(bus2.TRUE_CNT), 32'd3);
    step(1, 3'd1, 1, 16'h8000, 16'h8000, 0);
    idle(1);
    chk("t3_clr2", 32'(bus2.TRUE_CNT), 32'd0);
    chk("t3_clr8", 32'(bus.TRUE_CNT), 32'd0);

    // hold across NOP and idle, reserved code yields 0
    step(1, 3'd1, 0, 16'd7, 16'd7, 0);
    step(1, 3'd0, 0, 16'd1, 16'd2, 0);
    idle(0);
    chk("t4_nop_out", 32'(bus.CMP_OUT), 32'd1);
    chk("t4_nop_flag", 32'(bus.CMP_Flag), 32'd1);
    idle(0);
    chk("t4_idle_out", 32'(bus.CMP_OUT), 32'd1);
    chk("t4_idle_flag", 32'(bus.CMP_Flag), 32'd0);
    step(1, 3'd6, 0, 16'd3, 16'd3, 0);
    idle(0);
    chk("t4_rsv", 32'(bus.CMP_OUT), 32'd0);

    // reset with an op sitting in S1
    step(1, 3'd5, 0, 16'd1, 16'd2, 0);
    RST = 1'b0;
    bus.CMP_EN = 0;
    #1;
    model_reset();
    check_all();
    @(posedge CLK); #1;
    check_all();
    RST = 1'b1;
    idle(0);

`ifdef CMP_TRACK_EN
    idle(1);
    step(1, 3'd0, 1, 16'd3, 16'd0, 0);
    step(1, 3'd0, 1, 16'hFFF9, 16'd0, 0);
    step(1, 3'd0, 1, 16'd12, 16'd0, 0);
    step(1, 3'd0, 1, 16'd0, 16'd0, 0);
    idle(0);
    chk("t6_max", 32'(bus.RUN_MAX), 32'd12);
    chk("t6_min", 32'(bus.RUN_MIN), 32'h0000FFF9);
    idle(1);
    step(1, 3'd2, 1, 16'd4, 16'd0, 0);
    idle(0);
    chk("t6_max4", 32'(bus.RUN_MAX), 32'd4);
    chk("t6_min4", 32'(bus.RUN_MIN), 32'd4);
`endif

    // 8-bit counter saturation
    idle(1);
    for (int i = 0; i < 260; i++) step(1, 3'd5, 1, 16'(i), 16'hFFFF, 0);
    idle(0);
    chk("sat8", 32'(bus.TRUE_CNT), 32'd255);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra :
           (($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom));
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ra, rb, $urandom_range(0, 19) == 0);
    end
    idle(0);
    idle(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
